// File: rtl/sensor_avg_pkg.sv
// rtl/sensor_avg_pkg.sv - shared constants, trigger enum and width helper for the averaging bank
package sensor_avg_pkg;

  localparam int MAX_SHIFT_DEF  = 7;
  localparam int TICK_BITS_FAST = 16;
  localparam int TICK_BITS_SLOW = 22;

  typedef enum logic {
    TRG_TICK = 1'b0,
    TRG_EXT  = 1'b1
  } trg_sel_e;

  function automatic int acc_w(input int data_w, input int max_shift);
    return data_w + max_shift;
  endfunction

endpackage

// File: rtl/expo_avg_ch.sv
// rtl/expo_avg_ch.sv - one exponential-average channel with seed/hold and debounced plausibility fault
module expo_avg_ch
  import sensor_avg_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int FAULT_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic [2:0]        shift,
  input  logic              trg,
  input  logic              seed,
  input  logic              hold,
  input  logic [DATA_W-1:0] lim_lo,
  input  logic [DATA_W-1:0] lim_hi,
  input  logic              clr_fault,
  output logic [DATA_W-1:0] avg,
  output logic              avg_vld,
  output logic              upd,
  output logic              fault
);

  localparam int ACC_W = acc_w(DATA_W, MAX_SHIFT);
  localparam int IDX_W = $clog2(ACC_W);
  localparam logic [2:0] K_MAX = 3'(MAX_SHIFT);
  localparam logic [3:0] CNT_MAX = 4'(FAULT_CNT);

  logic [ACC_W-1:0] acc;
  logic [2:0]       k_q;
  logic [3:0]       cnt;

  logic [2:0]       k_new;
  logic [ACC_W-1:0] seed_acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_trg;
  logic             take;
  logic             oow;
  logic [3:0]       cnt_nxt;
  logic [IDX_W-1:0] k_idx;

  // k = 0 would disable smoothing entirely; clamp into 1..MAX_SHIFT
  function automatic logic [2:0] legal_k(input logic [2:0] s);
    if (s == 3'd0) return 3'd1;
    if (s > K_MAX) return K_MAX;
    return s;
  endfunction

  always_comb begin
    k_new    = legal_k(shift);
    seed_acc = {{MAX_SHIFT{1'b0}}, sample} << k_new;
    sum      = {1'b0, acc} - {1'b0, (acc >> k_q)} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample};
    acc_trg  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    take     = trg && !seed && !hold;
    oow      = (sample < lim_lo) || (sample > lim_hi);
    cnt_nxt  = 4'd0;
    if (oow) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
    k_idx    = IDX_W'(k_q);
  end

  assign avg = acc[k_idx +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      k_q     <= legal_k(shift);
      cnt     <= '0;
      fault   <= 1'b0;
      avg_vld <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd <= seed || take;
      if (seed || take) avg_vld <= 1'b1;

      if (seed) begin
        acc <= seed_acc;
        k_q <= k_new;
      end else if (take) begin
        acc <= acc_trg;
      end

      if (seed)           cnt <= '0;
      else if (take)      cnt <= cnt_nxt;
      else if (clr_fault) cnt <= '0;

      // a fault-setting sample beats a coincident clear
      if (take && cnt_nxt == CNT_MAX) fault <= 1'b1;
      else if (clr_fault)             fault <= 1'b0;
    end
  end

endmodule

// File: rtl/expo_avg_bank.sv
// rtl/expo_avg_bank.sv - N-channel exponential-average bank with shared periodic tick
module expo_avg_bank
  import sensor_avg_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 12,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int FAST_SIM  = 1,
  parameter int FAULT_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] sample,
  input  logic [NUM_CH*3-1:0]      shift,
  input  logic [NUM_CH-1:0]        trig_sel,
  input  logic [NUM_CH-1:0]        ext_strb,
  input  logic [NUM_CH-1:0]        seed,
  input  logic [NUM_CH-1:0]        hold,
  input  logic [NUM_CH*DATA_W-1:0] lim_lo,
  input  logic [NUM_CH*DATA_W-1:0] lim_hi,
  input  logic [NUM_CH-1:0]        clr_fault,
  output logic [NUM_CH*DATA_W-1:0] avg,
  output logic [NUM_CH-1:0]        avg_vld,
  output logic [NUM_CH-1:0]        upd,
  output logic [NUM_CH-1:0]        fault,
  output logic                     tick
);

  logic [TICK_BITS_SLOW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n) timer <= '0;
    else        timer <= timer + 1'b1;
  end

  assign tick = (FAST_SIM != 0) ? &timer[TICK_BITS_FAST-1:0] : &timer;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trg_sel_e sel;
    logic     trg;

    assign sel = trg_sel_e'(trig_sel[i]);
    assign trg = (sel == TRG_EXT) ? ext_strb[i] : tick;

    expo_avg_ch #(
      .DATA_W    (DATA_W),
      .MAX_SHIFT (MAX_SHIFT),
      .FAULT_CNT (FAULT_CNT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample    (sample[i*DATA_W +: DATA_W]),
      .shift     (shift[i*3 +: 3]),
      .trg       (trg),
      .seed      (seed[i]),
      .hold      (hold[i]),
      .lim_lo    (lim_lo[i*DATA_W +: DATA_W]),
      .lim_hi    (lim_hi[i*DATA_W +: DATA_W]),
      .clr_fault (clr_fault[i]),
      .avg       (avg[i*DATA_W +: DATA_W]),
      .avg_vld   (avg_vld[i]),
      .upd       (upd[i]),
      .fault     (fault[i])
    );
  end

endmodule

// File: tb/tb_expo_avg_bank.sv
// tb/tb_expo_avg_bank.sv - scoreboard bench for expo_avg_bank
module tb_expo_avg_bank;

  localparam int NUM_CH = 2;
  localparam int DW     = 12;
  localparam int ACC_W  = 19;
  localparam int FC     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NUM_CH*DW-1:0] sample, lim_lo, lim_hi;
  logic [NUM_CH*3-1:0]  shift;
  logic [NUM_CH-1:0]    trig_sel, ext_strb, seed, hold, clr_fault;
  logic [NUM_CH*DW-1:0] avg;
  logic [NUM_CH-1:0]    avg_vld, upd, fault;
  logic                 tick;

  expo_avg_bank #(.NUM_CH(2), .DATA_W(12), .MAX_SHIFT(7), .FAST_SIM(1), .FAULT_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .shift(shift), .trig_sel(trig_sel),
    .ext_strb(ext_strb), .seed(seed), .hold(hold), .lim_lo(lim_lo), .lim_hi(lim_hi),
    .clr_fault(clr_fault), .avg(avg), .avg_vld(avg_vld), .upd(upd), .fault(fault), .tick(tick)
  );

  typedef struct packed {
    logic [DW-1:0] a_v;
    logic          f_v;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   errors = 0;
  int   checks = 0;

  logic [ACC_W-1:0] m_acc[NUM_CH];
  int               m_k[NUM_CH];
  int               m_cnt[NUM_CH];
  bit               m_flt[NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic mon(input int c);
    exp_t e;
    int   n;
    n = (c == 0) ? sb0.size() : sb1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_upd ch%0d: upd=1 expected 0", c);
    end else begin
      e = (c == 0) ? sb0.pop_front() : sb1.pop_front();
      chk($sformatf("sb_avg ch%0d", c), 32'(avg[c*DW +: DW]), 32'(e.a_v));
      chk($sformatf("sb_fault ch%0d", c), 32'(fault[c]), 32'(e.f_v));
      chk($sformatf("sb_vld ch%0d", c), 32'(avg_vld[c]), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (upd[0]) mon(0);
      if (upd[1]) mon(1);
    end
  end

  // Drive one cycle of control for a channel and predict the response
  task automatic act(input int ch, input bit sd, input bit hd, input bit st, input bit cf, input bit tk);
    int               s, lo, hi, k, nc;
    longint           a;
    bit               take, oow;
    logic [ACC_W-1:0] t;
    exp_t             e;
    s  = int'(sample[ch*DW +: DW]);
    lo = int'(lim_lo[ch*DW +: DW]);
    hi = int'(lim_hi[ch*DW +: DW]);
    take = !sd && !hd && (trig_sel[ch] ? st : tk);
    seed[ch] = sd; hold[ch] = hd; ext_strb[ch] = st; clr_fault[ch] = cf;
    if (sd) begin
      k = int'(shift[ch*3 +: 3]);
      if (k == 0) k = 1;
      m_k[ch]   = k;
      a         = longint'(s) <<< k;
      m_acc[ch] = a[ACC_W-1:0];
      m_cnt[ch] = 0;
      if (cf) m_flt[ch] = 1'b0;
    end else if (take) begin
      a = longint'(m_acc[ch]) - longint'(m_acc[ch] >> m_k[ch]) + longint'(s);
      if (a > longint'((1 << ACC_W) - 1)) a = longint'((1 << ACC_W) - 1);
      m_acc[ch] = a[ACC_W-1:0];
      oow = (s < lo) || (s > hi);
      nc  = oow ? ((m_cnt[ch] >= FC) ? FC : m_cnt[ch] + 1) : 0;
      m_cnt[ch] = nc;
      if (nc == FC) m_flt[ch] = 1'b1;
      else if (cf)  m_flt[ch] = 1'b0;
    end else if (cf) begin
      m_flt[ch] = 1'b0;
      m_cnt[ch] = 0;
    end
    if (sd || take) begin
      t = m_acc[ch] >> m_k[ch];
      e.a_v = t[DW-1:0];
      e.f_v = m_flt[ch];
      if (ch == 0) sb0.push_back(e);
      else         sb1.push_back(e);
    end
    @(posedge clk); #1;
    seed[ch] = 1'b0; hold[ch] = 1'b0; ext_strb[ch] = 1'b0; clr_fault[ch] = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = '0;
      m_k[c]   = (shift[c*3 +: 3] == 3'd0) ? 1 : int'(shift[c*3 +: 3]);
      m_cnt[c] = 0;
      m_flt[c] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg"}, 32'(avg), 32'd0);
    chk({tag, "_vld"}, 32'(avg_vld), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    sample = '0; lim_lo = '0; lim_hi = '0;
    ext_strb = '0; seed = '0; hold = '0; clr_fault = '0;
    shift = {3'd5, 3'd2};
    trig_sel = 2'b10;
    sample[0 +: DW]  = 12'h400;
    lim_hi[0 +: DW]  = 12'hFFF;
    lim_lo[DW +: DW] = 12'h100;
    lim_hi[DW +: DW] = 12'hE00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    model_reset();
    rst_n = 1'b1;

    // Shared tick: first pulse 65535 cycles after reset release
    n = 0;
    while (!tick && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_tick_cycle", 32'(n), 32'd65535);
    if (tick) act(0, 0, 0, 0, 0, 1);
    chk("tick_step1", 32'(avg[0 +: DW]), 32'h100);
    chk("tick_upd", 32'(upd[0]), 32'd1);
    chk("tick_low_after", 32'(tick), 32'd0);

    trig_sel[0] = 1'b1;
    act(0, 0, 0, 1, 0, 0);
    chk("ch0_step2", 32'(avg[0 +: DW]), 32'h1C0);
    act(0, 0, 0, 1, 0, 0);
    chk("ch0_step3", 32'(avg[0 +: DW]), 32'h250);
    repeat (40) act(0, 0, 0, 1, 0, 0);
    chk("ch0_converged", 32'(avg[0 +: DW] == 12'h3FF || avg[0 +: DW] == 12'h400), 32'd1);

    // Channel 1 seeding and steady state
    sample[DW +: DW] = 12'h800;
    act(1, 1, 0, 0, 0, 0);
    chk("seed_avg", 32'(avg[DW +: DW]), 32'h800);
    chk("seed_vld", 32'(avg_vld[1]), 32'd1);
    chk("seed_upd", 32'(upd[1]), 32'd1);
    repeat (10) act(1, 0, 0, 1, 0, 0);
    chk("steady_avg", 32'(avg[DW +: DW]), 32'h800);

    sample[DW +: DW] = 12'h300;
    act(1, 1, 0, 1, 0, 0);
    chk("seed_beats_strb", 32'(avg[DW +: DW]), 32'h300);
    sample[DW +: DW] = 12'h900;
    act(1, 0, 1, 1, 0, 0);
    chk("hold_avg", 32'(avg[DW +: DW]), 32'h300);
    chk("hold_upd", 32'(upd[1]), 32'd0);

    // Debounced fault
    sample[DW +: DW] = 12'hF00;
    repeat (3) act(1, 0, 0, 1, 0, 0);
    chk("fault_after3", 32'(fault[1]), 32'd0);
    act(1, 0, 0, 1, 0, 0);
    chk("fault_after4", 32'(fault[1]), 32'd1);
    act(1, 0, 0, 0, 1, 0);
    chk("fault_cleared", 32'(fault[1]), 32'd0);

    repeat (3) act(1, 0, 0, 1, 0, 0);
    sample[DW +: DW] = 12'h500;
    act(1, 0, 0, 1, 0, 0);
    sample[DW +: DW] = 12'hF00;
    act(1, 0, 0, 1, 0, 0);
    chk("fault_run_broken", 32'(fault[1]), 32'd0);

    sample[DW +: DW] = 12'h500;
    act(1, 1, 0, 0, 0, 0);
    sample[DW +: DW] = 12'hF00;
    repeat (3) act(1, 0, 0, 1, 0, 0);
    act(1, 0, 0, 1, 1, 0);
    chk("set_beats_clr", 32'(fault[1]), 32'd1);
    act(1, 0, 0, 0, 1, 0);

    lim_lo[DW +: DW] = 12'h900;
    lim_hi[DW +: DW] = 12'h100;
    sample[DW +: DW] = 12'h500;
    repeat (4) act(1, 0, 0, 1, 0, 0);
    chk("inverted_window", 32'(fault[1]), 32'd1);
    act(1, 0, 0, 0, 1, 0);
    lim_lo[DW +: DW] = 12'h100;
    lim_hi[DW +: DW] = 12'hE00;

    // Shift latched only at seed
    shift[3 +: 3] = 3'd2;
    sample[DW +: DW] = 12'h400;
    act(1, 1, 0, 0, 0, 0);
    shift[3 +: 3] = 3'd6;
    sample[DW +: DW] = 12'h800;
    act(1, 0, 0, 1, 0, 0);
    chk("k_not_relatched", 32'(avg[DW +: DW]), 32'h500);
    sample[DW +: DW] = 12'h200;
    act(1, 1, 0, 0, 0, 0);
    chk("k6_seed", 32'(avg[DW +: DW]), 32'h200);
    sample[DW +: DW] = 12'h600;
    act(1, 0, 0, 1, 0, 0);
    chk("k6_step", 32'(avg[DW +: DW]), 32'h210);

    shift[3 +: 3] = 3'd0;
    sample[DW +: DW] = 12'h100;
    act(1, 1, 0, 0, 0, 0);
    sample[DW +: DW] = 12'h000;
    act(1, 0, 0, 1, 0, 0);
    chk("k0_as_k1", 32'(avg[DW +: DW]), 32'h080);

    // Full-scale input at the widest shift
    lim_lo[DW +: DW] = 12'h000;
    lim_hi[DW +: DW] = 12'hFFF;
    shift[3 +: 3] = 3'd7;
    sample[DW +: DW] = 12'hFFF;
    act(1, 1, 0, 0, 0, 0);
    repeat (2000) act(1, 0, 0, 1, 0, 0);
    chk("fullscale_avg", 32'(avg[DW +: DW]), 32'hFFF);

    repeat (2) @(posedge clk);
    #1;
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("midrun_reset");
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_avg", 32'(avg), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expo_avg_bank.md
Name: expo_avg_bank

Overview:
- Parametrised N-channel exponential-average bank; successor to the fixed torque/current averaging in the sensor-conditioning path.
- Each channel has a runtime-selectable smoothing shift k (alpha = 1/2^k).
- Each channel selects its sample trigger: shared periodic tick or its own external strobe (e.g. cadence_rise).
- Adds per-channel seeding, hold, valid/update flags and a debounced sticky plausibility fault. Feeds desiredDrive, error computation and telemetry.

Parameters:
NUM_CH, 2, number of channels
DATA_W, 12, unsigned sample width
MAX_SHIFT, 7, largest legal k; accumulator width ACC_W = DATA_W + MAX_SHIFT
FAST_SIM, 1, 1: tick when timer[15:0] all ones; 0: tick when timer[21:0] all ones
FAULT_CNT, 4, consecutive out-of-window samples needed to set fault (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample  in  NUM_CH*DATA_W  per-channel raw samples, ch0 in LSBs
shift  in  NUM_CH*3  per-channel k, legal 1..MAX_SHIFT
trig_sel  in  NUM_CH  1: channel uses ext_strb; 0: uses internal tick
ext_strb  in  NUM_CH  per-channel external sample strobes, single-cycle
seed  in  NUM_CH  load accumulator from current sample (e.g. pedaling resumes)
hold  in  NUM_CH  freeze accumulator and fault counter
lim_lo  in  NUM_CH*DATA_W  plausibility low limit, inclusive
lim_hi  in  NUM_CH*DATA_W  plausibility high limit, inclusive
clr_fault  in  NUM_CH  clear sticky fault
avg  out  NUM_CH*DATA_W  averaged value per channel
avg_vld  out  NUM_CH  channel has been seeded or sampled since reset
upd  out  NUM_CH  one-cycle pulse: avg changed this cycle
fault  out  NUM_CH  sticky plausibility fault
tick  out  1  shared periodic sample pulse

Behaviour:
- Reset (rst_n low at clk edge):
  - timer = 0; all accumulators = 0; avg = 0.
  - avg_vld = 0, upd = 0, fault = 0, fault counters = 0.
  - k_q[ch] loads from shift[ch].
- Timer:
  - 22-bit free-running counter, wraps naturally.
  - tick is combinational from timer per FAST_SIM, so with FAST_SIM=1 it pulses every 65536 cycles; first tick at cycle 65535 after reset.
- Trigger: trg[ch] = trig_sel[ch] ? ext_strb[ch] : tick.
- Priority per channel each cycle: seed > hold > trg.
  - seed: acc <= sample << k_new; k_q <= shift[ch] (shift is latched only here and at reset, never mid-average).
    - fault counter cleared. Seeding a value outside the window does not count toward the fault.
  - hold high: accumulator, counter and k_q unchanged; trg ignored.
  - trg: acc <= acc - (acc >> k_q) + sample.
    - Computed in ACC_W+1 bits, then saturates at 2^ACC_W-1. No overflow is possible when k_q <= MAX_SHIFT; saturation is kept as a guard.
- avg[ch] = acc >> k_q, truncated to DATA_W bits. It is combinational from registers and valid the cycle after the seed/trg edge (latency 1).
- Steady state: a constant sample s converges to avg = s.
- avg_vld sets on the first seed or accepted trg and stays set until reset.
- upd is registered and high the cycle after an accepted seed or trg, aligned with the new avg.
- Fault:
  - On each accepted trg, out = sample < lim_lo or sample > lim_hi.
  - If out: counter increments, saturating at FAULT_CNT; otherwise counter = 0.
  - fault sets when the counter reaches FAULT_CNT; the set is visible with upd.
  - Fault is sticky; clr_fault clears fault and counter.
  - clr_fault and a fault-setting trg in the same cycle: the set wins.
  - lim_lo > lim_hi: every sample counts as out.
- Illegal shift = 0 is treated as 1.
- Reset mid-operation discards all state immediately; the next edge after release behaves as cycle 0.

Decomposition:
- Package sensor_avg_pkg:
  - MAX_SHIFT default
  - ACC_W function
  - TICK_BITS_FAST = 16, TICK_BITS_SLOW = 22
  - trigger-select enum {TRG_TICK, TRG_EXT}
- Sub-module expo_avg_ch: one channel containing the accumulator, k_q, valid, upd and fault counter.
- Top: timer/tick logic plus a generate loop over NUM_CH and port slicing.

Test Plan:
- Reset, FAST_SIM=1, ch0 trig_sel=0, sample=0x400, k=2: avg steps 0x100, 0x1C0, 0x250… and reaches 0x3FF/0x400 within about 40 ticks. tick occurs at cycles 65535, 131071…; upd aligns with each tick+1.
- ch1 trig_sel=1, k=5, seed with sample=0x800: next cycle avg=0x800, avg_vld=1, upd=1. Ten ext_strb pulses at sample=0x800 leave avg=0x800.
- seed and ext_strb in the same cycle: accumulator = sample<<k, no accumulate. hold=1 with ext_strb: avg and upd unchanged.
- lim_lo=0x100, lim_hi=0xE00, FAULT_CNT=4, sample=0xF00: fault rises on the 4th strobe.
  - Variant: 3 outs then 1 in-window sample resets the counter, so no fault.
  - clr_fault clears it; clr_fault coincident with the 4th out leaves fault=1.
- shift changed from 2 to 6 without seed: k_q stays 2. After seed, k_q=6 and avg=sample.
- Sample 0xFFF at k=7 for 2000 strobes: avg=0xFFF, no wrap. Assert rst_n low mid-run: all outputs 0 on the next edge.
